// File: rtl/iccm_arb_pkg.sv
// Shared types for the ICCM SRAM arbiter: FSM states, SRAM request bundle
// and read-return owner bit positions.
package iccm_arb_pkg;

    localparam int ICCM_ADDR_W     = 11;
    localparam int ICCM_DATA_W     = 32;
    localparam int ICCM_NUM_WMASKS = ICCM_DATA_W / 8;

    typedef enum logic [1:0] {
        SHARED  = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                       we;
        logic [ICCM_ADDR_W-1:0]     addr;
        logic [ICCM_DATA_W-1:0]     wdata;
        logic [ICCM_NUM_WMASKS-1:0] wmask;
    } sram_req_t;

    // Bit positions in the one-hot read-return owner vector
    localparam int OWN_P0 = 0;
    localparam int OWN_P1 = 1;

endpackage

// File: rtl/iccm_arb_starve_ctr.sv
// Saturating starvation counter: clear wins, then increment up to LIMIT,
// otherwise hold. at_limit_o flags that the starved port must be served.
module iccm_arb_starve_ctr #(
    parameter int LIMIT = 8,
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    assign at_limit_o = (count_reg == WIDTH'(LIMIT));

    always_comb begin
        count_next = count_reg;
        if (clr_i) begin
            count_next = '0;
        end else if (inc_i && !at_limit_o) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/iccm_sram_arbiter.sv
// Two-port arbiter in front of a single-port ICCM SRAM: fixed priority to the
// boot loader with starvation aging for the fetch port, plus an exclusive lock.
module iccm_sram_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int ADDR_W       = ICCM_ADDR_W,
    parameter int DATA_W       = ICCM_DATA_W,
    parameter int NUM_WMASKS   = ICCM_NUM_WMASKS,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  p0_lock_i,
    input  logic                  p0_req_i,
    input  logic                  p0_we_i,
    input  logic [ADDR_W-1:0]     p0_addr_i,
    input  logic [DATA_W-1:0]     p0_wdata_i,
    input  logic [NUM_WMASKS-1:0] p0_wmask_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_W-1:0]     p0_rdata_o,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [ADDR_W-1:0]     p1_addr_i,
    input  logic [DATA_W-1:0]     p1_wdata_i,
    input  logic [NUM_WMASKS-1:0] p1_wmask_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_W-1:0]     p1_rdata_o,
    output logic                  locked_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [DATA_W-1:0]     sram_wdata_o,
    input  logic [DATA_W-1:0]     sram_rdata_i
);

    arb_state_e  state_reg;
    arb_state_e  state_next;
    logic        p0_gnt;
    logic        p1_gnt;
    logic        at_limit;
    logic        starve_clr;
    logic        starve_inc;
    logic [1:0]  owner_reg;
    logic [1:0]  owner_next;
    sram_req_t   p0_req_s;
    sram_req_t   p1_req_s;
    sram_req_t   sel_req;
    logic [DATA_W-1:0] rdata_port [2];

    always_comb begin
        state_next = state_reg;
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        unique case (state_reg)
            SHARED: begin
                // Port 0 wins conflicts until port 1 has waited STARVE_LIMIT cycles
                p0_gnt = p0_req_i && !(p1_req_i && at_limit);
                p1_gnt = p1_req_i && (!p0_req_i || at_limit);
                if (p0_lock_i) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                p0_gnt = p0_req_i;
                if (!p0_lock_i) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = p0_lock_i ? LOCKED : SHARED;
            end
            default: begin
                state_next = SHARED;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= SHARED;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    // Counter reads 0 whenever the FSM sits outside SHARED
    assign starve_clr = (state_reg != SHARED) || (state_next != SHARED)
                        || p1_gnt || !p1_req_i;
    assign starve_inc = (state_reg == SHARED) && p1_req_i && !p1_gnt;

    iccm_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .WIDTH (8)
    ) u_starve_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (starve_clr),
        .inc_i      (starve_inc),
        .at_limit_o (at_limit)
    );

    assign p0_req_s = '{we: p0_we_i, addr: p0_addr_i, wdata: p0_wdata_i, wmask: p0_wmask_i};
    assign p1_req_s = '{we: p1_we_i, addr: p1_addr_i, wdata: p1_wdata_i, wmask: p1_wmask_i};

    always_comb begin
        sel_req = '0;
        if (p1_gnt) begin
            sel_req = p1_req_s;
        end else if (p0_gnt) begin
            sel_req = p0_req_s;
        end
    end

    assign sram_csb_o   = !(p0_gnt || p1_gnt);
    assign sram_web_o   = sram_csb_o ? 1'b1 : ~sel_req.we;
    assign sram_addr_o  = sel_req.addr;
    assign sram_wdata_o = sel_req.wdata;
    assign sram_wmask_o = sel_req.wmask;

    assign owner_next[OWN_P0] = p0_gnt && !p0_we_i;
    assign owner_next[OWN_P1] = p1_gnt && !p1_we_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_steer
            assign rdata_port[gi] = owner_reg[gi] ? sram_rdata_i : '0;
        end
    endgenerate

    assign p0_gnt_o    = p0_gnt;
    assign p1_gnt_o    = p1_gnt;
    assign p0_rvalid_o = owner_reg[OWN_P0];
    assign p1_rvalid_o = owner_reg[OWN_P1];
    assign p0_rdata_o  = rdata_port[OWN_P0];
    assign p1_rdata_o  = rdata_port[OWN_P1];
    assign locked_o    = (state_reg == LOCKED);

endmodule

// File: tb/tb_iccm_sram_arbiter.sv
// Directed bench for iccm_sram_arbiter: stimulus queues expected grants and
// read data; a negedge monitor pops and compares whenever the DUT responds.
module tb_iccm_sram_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } gnt_t;

    logic        clk;
    logic        rst;
    logic        p0_lock, p0_req, p0_we, p1_req, p1_we;
    logic [10:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, locked;
    logic [31:0] p0_rdata, p1_rdata;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [10:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] mem [0:2047];
    gnt_t        exp_gnt_q [$];
    logic [31:0] exp_rd0_q [$];
    logic [31:0] exp_rd1_q [$];
    logic        exp_locked;
    int          checks;
    int          errors;

    iccm_sram_arbiter #(
        .ADDR_W       (11),
        .DATA_W       (32),
        .NUM_WMASKS   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p0_lock_i    (p0_lock),
        .p0_req_i     (p0_req),
        .p0_we_i      (p0_we),
        .p0_addr_i    (p0_addr),
        .p0_wdata_i   (p0_wdata),
        .p0_wmask_i   (p0_wmask),
        .p0_gnt_o     (p0_gnt),
        .p0_rvalid_o  (p0_rvalid),
        .p0_rdata_o   (p0_rdata),
        .p1_req_i     (p1_req),
        .p1_we_i      (p1_we),
        .p1_addr_i    (p1_addr),
        .p1_wdata_i   (p1_wdata),
        .p1_wmask_i   (p1_wmask),
        .p1_gnt_o     (p1_gnt),
        .p1_rvalid_o  (p1_rvalid),
        .p1_rdata_o   (p1_rdata),
        .locked_o     (locked),
        .sram_csb_o   (sram_csb),
        .sram_web_o   (sram_web),
        .sram_wmask_o (sram_wmask),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Monitor
    logic [117:0] act_vec;
    gnt_t         e;
    logic [31:0]  d;
    always @(negedge clk) begin
        if (rst) begin
            act_vec = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, locked, sram_csb, sram_web,
                       sram_addr, sram_wdata, sram_wmask, p0_rdata, p1_rdata};
            checks++;
            if (act_vec !== {5'b0, 2'b11, 11'h0, 32'h0, 4'h0, 32'h0, 32'h0}) begin
                errors++;
                $display("FAIL reset_state got %h want %h", act_vec,
                         {5'b0, 2'b11, 11'h0, 32'h0, 4'h0, 32'h0, 32'h0});
            end
        end else begin
            checks++;
            if (p0_gnt && p1_gnt) begin
                errors++;
                $display("FAIL single_grant got p0_gnt=1 p1_gnt=1 want at most one");
            end
            if (p0_gnt || p1_gnt) begin
                checks++;
                if (exp_gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant got p0_gnt=%b p1_gnt=%b want none", p0_gnt, p1_gnt);
                end else begin
                    e = exp_gnt_q.pop_front();
                    if ({p1_gnt, sram_csb, sram_web, sram_addr, sram_wdata, sram_wmask} !==
                        {e.port, 1'b0, ~e.we, e.addr, e.wdata, e.wmask}) begin
                        errors++;
                        $display("FAIL grant_drive got port=%b csb=%b web=%b addr=%h wdata=%h wmask=%b want port=%b csb=0 web=%b addr=%h wdata=%h wmask=%b",
                                 p1_gnt, sram_csb, sram_web, sram_addr, sram_wdata, sram_wmask,
                                 e.port, ~e.we, e.addr, e.wdata, e.wmask);
                    end
                end
            end else begin
                checks++;
                if ({sram_csb, sram_web, sram_addr, sram_wdata, sram_wmask} !== {2'b11, 47'h0}) begin
                    errors++;
                    $display("FAIL idle_drive got csb=%b web=%b addr=%h wdata=%h wmask=%b want 1 1 0 0 0",
                             sram_csb, sram_web, sram_addr, sram_wdata, sram_wmask);
                end
            end
            checks++;
            if (p0_rvalid) begin
                if (exp_rd0_q.size() == 0) begin
                    errors++;
                    $display("FAIL p0_rvalid_unexpected got rvalid=1 rdata=%h want rvalid=0", p0_rdata);
                end else begin
                    d = exp_rd0_q.pop_front();
                    if (p0_rdata !== d) begin
                        errors++;
                        $display("FAIL p0_rdata got %h want %h", p0_rdata, d);
                    end
                end
            end else if (p0_rdata !== 32'h0) begin
                errors++;
                $display("FAIL p0_rdata_idle got %h want 00000000", p0_rdata);
            end
            checks++;
            if (p1_rvalid) begin
                if (exp_rd1_q.size() == 0) begin
                    errors++;
                    $display("FAIL p1_rvalid_unexpected got rvalid=1 rdata=%h want rvalid=0", p1_rdata);
                end else begin
                    d = exp_rd1_q.pop_front();
                    if (p1_rdata !== d) begin
                        errors++;
                        $display("FAIL p1_rdata got %h want %h", p1_rdata, d);
                    end
                end
            end else if (p1_rdata !== 32'h0) begin
                errors++;
                $display("FAIL p1_rdata_idle got %h want 00000000", p1_rdata);
            end
            checks++;
            if (locked !== exp_locked) begin
                errors++;
                $display("FAIL locked got %b want %b", locked, exp_locked);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic we, input logic [10:0] a, input logic [31:0] wd, input logic [3:0] m);
        p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd; p0_wmask = m;
    endtask

    task automatic set_p1(input logic we, input logic [10:0] a, input logic [31:0] wd, input logic [3:0] m);
        p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd; p1_wmask = m;
    endtask

    task automatic push_gnt(input logic port, input logic we, input logic [10:0] a,
                            input logic [31:0] wd, input logic [3:0] m);
        gnt_t g;
        g.port = port; g.we = we; g.addr = a; g.wdata = wd; g.wmask = m;
        exp_gnt_q.push_back(g);
        $display("tx port%0d %s addr=%h wdata=%h wmask=%b", port, we ? "WR" : "RD", a, wd, m);
    endtask

    initial begin
        checks = 0; errors = 0; exp_locked = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
        mem[11'h010] <= 32'hDEADBEEF;
        mem[11'h020] <= 32'hA5A5_0020;
        sram_rdata <= 32'h0;
        rst = 1'b1; p0_lock = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wmask = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wmask = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Port 1 single read
        set_p1(1'b0, 11'h010, 32'h0, 4'h0);
        push_gnt(1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
        exp_rd1_q.push_back(32'hDEADBEEF);
        tick(); p1_req = 1'b0; tick();

        // Port 0 masked write to top address, then read it back
        set_p0(1'b1, 11'h7FF, 32'h12345678, 4'b0101);
        push_gnt(1'b0, 1'b1, 11'h7FF, 32'h12345678, 4'b0101);
        tick(); p0_req = 1'b0; tick();
        set_p0(1'b0, 11'h7FF, 32'h0, 4'h0);
        push_gnt(1'b0, 1'b0, 11'h7FF, 32'h0, 4'h0);
        exp_rd0_q.push_back(32'h0034_0078);
        tick(); p0_req = 1'b0; tick();

        // Continuous contention: 8 port 0 grants then 1 port 1 grant, repeating
        set_p0(1'b1, 11'h100, 32'h0000_0100, 4'hF);
        set_p1(1'b0, 11'h020, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) push_gnt(1'b0, 1'b1, 11'h100, 32'h0000_0100, 4'hF);
            push_gnt(1'b1, 1'b0, 11'h020, 32'h0, 4'h0);
            exp_rd1_q.push_back(32'hA5A5_0020);
        end
        repeat (27) tick();
        p0_req = 1'b0; p1_req = 1'b0;
        tick(); tick();

        // Lock session held 20 cycles while port 1 keeps requesting
        p0_lock = 1'b1;
        set_p1(1'b0, 11'h020, 32'h0, 4'h0);
        push_gnt(1'b1, 1'b0, 11'h020, 32'h0, 4'h0);
        exp_rd1_q.push_back(32'hA5A5_0020);
        tick();
        for (int j = 1; j < 20; j++) begin
            exp_locked = 1'b1;
            if (j >= 5 && j <= 7) begin
                set_p0(1'b1, 11'h300 + 11'(j), 32'hB000_0000 + 32'(j), 4'hF);
                push_gnt(1'b0, 1'b1, 11'h300 + 11'(j), 32'hB000_0000 + 32'(j), 4'hF);
            end else begin
                p0_req = 1'b0;
            end
            tick();
        end
        p0_lock = 1'b0; p0_req = 1'b0;
        tick();
        exp_locked = 1'b0;
        tick();
        push_gnt(1'b1, 1'b0, 11'h020, 32'h0, 4'h0);
        exp_rd1_q.push_back(32'hA5A5_0020);
        tick(); p1_req = 1'b0; tick();

        // Reset the cycle after a port 1 read grant: its rvalid must vanish
        set_p1(1'b0, 11'h010, 32'h0, 4'h0);
        push_gnt(1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
        tick();
        rst = 1'b1; p1_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        set_p1(1'b0, 11'h010, 32'h0, 4'h0);
        push_gnt(1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
        exp_rd1_q.push_back(32'hDEADBEEF);
        tick(); p1_req = 1'b0; tick();

        // Port 0 alternating write/read, 16 back-to-back accesses
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                set_p0(1'b1, 11'h200 + 11'(i / 2), 32'hC0DE_0000 + 32'(i), 4'hF);
                push_gnt(1'b0, 1'b1, 11'h200 + 11'(i / 2), 32'hC0DE_0000 + 32'(i), 4'hF);
            end else begin
                set_p0(1'b0, 11'h200 + 11'(i / 2), 32'h0, 4'h0);
                push_gnt(1'b0, 1'b0, 11'h200 + 11'(i / 2), 32'h0, 4'h0);
                exp_rd0_q.push_back(32'hC0DE_0000 + 32'(i - 1));
            end
            tick();
        end
        p0_req = 1'b0;
        repeat (3) tick();

        checks++;
        if (exp_gnt_q.size() != 0) begin
            errors++;
            $display("FAIL missing_grants got %0d outstanding want 0", exp_gnt_q.size());
        end
        checks++;
        if (exp_rd0_q.size() != 0) begin
            errors++;
            $display("FAIL missing_p0_rvalid got %0d outstanding want 0", exp_rd0_q.size());
        end
        checks++;
        if (exp_rd1_q.size() != 0) begin
            errors++;
            $display("FAIL missing_p1_rvalid got %0d outstanding want 0", exp_rd1_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iccm_sram_arbiter.md
Name: iccm_sram_arbiter

Overview:
- Shares one single-port ICCM SRAM macro (active-low chip select and write enable, 1-cycle read latency) between two requesters.
- Port 0 is the boot-programming path: the UART loader writing instruction words.
- Port 1 is the TL-UL instruction-memory adapter serving core fetch and debug accesses.
- Provides fixed priority with anti-starvation aging, an exclusive lock for programming sessions, and read-data return steering.

Parameters:
- ADDR_W, 11, SRAM word address width
- DATA_W, 32, data width
- NUM_WMASKS, 4, write byte-mask width (DATA_W/8)
- STARVE_LIMIT, 8, consecutive denied cycles of port 1 before it is force-granted (range 1..255)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- p0_lock_i  in  1  port 0 requests exclusive ownership (programming session)
- p0_req_i  in  1  port 0 access request
- p0_we_i  in  1  port 0 write (1) / read (0)
- p0_addr_i  in  ADDR_W  port 0 word address
- p0_wdata_i  in  DATA_W  port 0 write data
- p0_wmask_i  in  NUM_WMASKS  port 0 byte mask
- p0_gnt_o  out  1  port 0 access accepted this cycle
- p0_rvalid_o  out  1  port 0 read data valid
- p0_rdata_o  out  DATA_W  port 0 read data
- p1_req_i / p1_we_i / p1_addr_i / p1_wdata_i / p1_wmask_i / p1_gnt_o / p1_rvalid_o / p1_rdata_o: same as port 0, for port 1
- locked_o  out  1  lock active (port 1 fully blocked)
- sram_csb_o  out  1  SRAM chip select, active low
- sram_web_o  out  1  SRAM write enable, active low
- sram_wmask_o  out  NUM_WMASKS  byte mask
- sram_addr_o  out  ADDR_W  address
- sram_wdata_o  out  DATA_W  write data
- sram_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read select

Behaviour:
- Reset values:
  - sram_csb_o=1, sram_web_o=1.
  - sram_addr_o, sram_wdata_o and sram_wmask_o = 0.
  - All gnt, rvalid and rdata outputs = 0; locked_o=0.
  - Starve counter 0; FSM in SHARED.
- Handshake:
  - A request is accepted on a cycle where req_i=1 and gnt_o=1.
  - gnt_o is combinational from req_i, the FSM state and the counter.
  - The requester holds its request fields stable until granted.
  - At most one grant per cycle.
- SRAM drive: combinational from the granted port that cycle.
  - csb_o = 0; web_o = ~we.
  - addr, wdata and wmask are passed through unchanged.
  - With no grant: csb_o=1, web_o=1; addr, wdata and wmask hold 0.
- Read return:
  - A registered owner flag is set on each read grant.
  - The next cycle, that port's rvalid_o=1 and its rdata_o = sram_rdata_i; the other port's rdata_o = 0.
  - Writes produce no rvalid.
  - Back-to-back reads sustain 1 per cycle.
- FSM states:
  - SHARED: both ports arbitrate.
  - LOCKED: only port 0 may be granted; locked_o=1.
  - RELEASE: one cycle with no grants, to drain any pending rvalid; then return to SHARED.
- FSM transitions:
  - SHARED -> LOCKED when p0_lock_i=1. The transition cycle itself still arbitrates as SHARED.
  - LOCKED -> RELEASE when p0_lock_i=0.
  - RELEASE -> SHARED unconditionally. If p0_lock_i re-asserts during RELEASE, go to LOCKED instead.
- Arbitration in SHARED:
  - Port 0 wins on conflict, unless the starve counter equals STARVE_LIMIT.
  - At the limit, port 1 is granted and port 0 is denied that cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle that p1_req_i=1 and p1_gnt_o=0 in SHARED.
  - Clears on any port 1 grant and when p1_req_i=0.
  - Held at 0 in LOCKED and RELEASE.
- Edge cases:
  - Same address on both ports: no special handling, serialized by grant order.
  - Reset mid-read: pending rvalid is discarded; no rvalid appears after reset deassertion.

Decomposition:
- Package iccm_arb_pkg holds:
  - arb_state_e enum {SHARED, LOCKED, RELEASE}
  - sram_req_t struct {we, addr, wdata, wmask}
  - owner encoding constants OWN_P0, OWN_P1
- Sub-module iccm_arb_starve_ctr: saturating counter with clear/hold/inc and an at_limit output. Everything else stays in the top module.

Test Plan:
- Port 1 reads addr 0x010 alone, SRAM returns 0xDEADBEEF -> p1_gnt_o=1 in cycle 0 with csb_o=0, web_o=1, addr_o=0x010; p1_rvalid_o=1 and p1_rdata_o=0xDEADBEEF in cycle 1; p0_rvalid_o=0.
- Port 0 writes 0x12345678 to 0x7FF with mask 4'b0101 -> csb_o=0, web_o=0, wmask_o=4'b0101, addr_o=0x7FF in the grant cycle; no rvalid on either port.
- Both ports request continuously, STARVE_LIMIT=8 -> port 0 granted 8 cycles, port 1 granted on the 9th, then repeats with period 9; counter returns to 0 after each port 1 grant.
- p0_lock_i asserted for 20 cycles while p1_req_i=1 -> locked_o=1 from the cycle after lock assertion; p1_gnt_o=0 throughout LOCKED and RELEASE; port 1 granted on the 2nd cycle after lock deassertion; counter stays 0.
- Reset asserted the cycle after a port 1 read grant -> p1_rvalid_o stays 0; all outputs at reset values; first post-reset read behaves as in scenario 1.
- Alternating read/write from port 0, 16 back-to-back accesses -> one grant per cycle; rvalid only for the cycles following reads, with correct data.
